sram_access_arbiter: RTL and testbench
======================================

Name: sram_access_arbiter

Overview:
- Shares one single-port line SRAM between NUM_REQ requesters. One line = BITWIDTH x WIDTH bits, i.e. one full SRAM_i/SRAM_o-shaped word.
- Round-robin grant with valid/ready handshake.
- Optional locked bursts, bounded by MAX_BURST.
- Registered SRAM command; read data is returned to the issuing requester after a fixed latency.
- Sits between the compute/load engines and the sram_controler-wrapped macro.

Parameters:
- BITWIDTH, 256, elements per line.
- WIDTH, 16, bits per element; also the address width.
- NUM_REQ, 2, number of requesters, 2..8.
- READ_LAT, 1, SRAM cycles from CE (read) to valid SRAM_RDATA_i, 1..4.
- MAX_BURST, 8, maximum consecutive beats a locked requester may hold the grant.

Ports:
- CKL_i  in  1  clock, rising edge.
- RST_i  in  1  synchronous active-high reset.
- req_valid_i  in  [NUM_REQ]  request valid.
- req_ready_o  out  [NUM_REQ]  request accepted this cycle; combinational.
- req_we_i  in  [NUM_REQ]  1 = write, 0 = read.
- req_lock_i  in  [NUM_REQ]  keep grant after this beat.
- req_addr_i  in  [NUM_REQ][WIDTH]  line address.
- req_wdata_i  in  [NUM_REQ][BITWIDTH][WIDTH]  write line.
- rsp_valid_o  out  [NUM_REQ]  one-hot read response.
- rsp_rdata_o  out  [BITWIDTH][WIDTH]  shared read-data bus.
- SRAM_CE_o  out  1  SRAM access enable.
- SRAM_WE_o  out  1  SRAM write enable.
- SRAM_ADDR_o  out  WIDTH  SRAM address.
- SRAM_WDATA_o  out  [BITWIDTH][WIDTH]  SRAM write data.
- SRAM_RDATA_i  in  [BITWIDTH][WIDTH]  SRAM read data.

Behaviour:
- Clock and reset: one clock CKL_i; RST_i is synchronous and active-high.
- Reset values:
  - All registered outputs are 0: SRAM_*_o, rsp_valid_o, rsp_rdata_o.
  - req_ready_o is 0 while RST_i is high.
  - rr_ptr = 0, state = ARB, burst_cnt = 0, read-tag pipeline cleared.
- Handshake:
  - Beat on requester i occurs when req_valid_i[i] and req_ready_o[i] are both high.
  - req_ready_o is one-hot or zero.
  - At most one beat per cycle; full throughput of 1 beat/cycle.
  - A requester must hold valid/we/lock/addr/wdata stable until accepted. No revocation.
- ARB state:
  - Grant goes to the first valid requester scanning from rr_ptr upward, with wrap.
  - On a beat by i: rr_ptr <= (i+1) mod NUM_REQ.
  - If req_lock_i[i]=1, go to LOCK(owner=i) with burst_cnt <= 1.
- LOCK state:
  - Only the owner may be granted; other requesters see ready=0.
  - Each owner beat increments burst_cnt.
  - Return to ARB when any of these holds:
    - the owner's beat has lock=0;
    - req_valid_i[owner]=0 in any cycle (lock release, no beat);
    - a beat makes burst_cnt reach MAX_BURST (forced release; the lock bit is ignored).
  - After release, rr_ptr = owner+1, so others are served first.
- Command timing:
  - Beat at edge k -> during cycle k+1: SRAM_CE_o=1, SRAM_WE_o=we, SRAM_ADDR_o=addr, SRAM_WDATA_o=wdata.
  - No beat -> CE=0, WE=0; ADDR/WDATA hold their previous values.
- Reads:
  - A tag (valid, requester id) shifts through a READ_LAT+1 deep pipeline.
  - rsp_valid_o[id]=1 and rsp_rdata_o=SRAM_RDATA_i (registered) during cycle k+2+READ_LAT.
  - Total read latency is READ_LAT+2 cycles from the beat; READ_LAT=1 gives 3.
  - rsp_rdata_o holds its value when rsp_valid_o=0.
  - There is no response backpressure; requesters must always accept.
- Writes: produce no response.
- Ordering:
  - Accesses are issued in beat order.
  - A read after a write to the same address, beats k and k+1, returns the new data.
- Width rules: addresses pass through unmodified, with no wrap or bounds check; the SRAM depth is the full 2^WIDTH.
- Reset mid-operation: in-flight reads are dropped with no rsp_valid_o; any LOCK is released.
- Simultaneous events: RST_i has priority over any beat in the same cycle. A lock-release condition and the MAX_BURST cap in the same cycle give a single transition to ARB.

Decomposition:
- Package sram_pkg holds:
  - localparams BITWIDTH and WIDTH;
  - typedef line_t = logic [BITWIDTH-1:0][WIDTH-1:0];
  - typedef addr_t = logic [WIDTH-1:0];
  - enum arb_state_e {ARB, LOCK}.
- One sub-module, sram_rr_arbiter: combinational priority scan from rr_ptr plus the rr_ptr register. Lock FSM, command registers and the tag pipeline stay in the top.

Test Plan:
- Single read:
  - Stimulus: READ_LAT=1; req0 reads addr 0x0010; the SRAM model returns a line with element j = j.
  - Required: CE/WE=1/0 with addr 0x0010 one cycle after the beat; rsp_valid_o=2'b01 exactly 3 cycles after the beat with matching data.
- Round-robin contention:
  - Stimulus: req0 and req1 both issue 4 continuous unlocked reads.
  - Required: grants alternate 0,1,0,1,...; one beat per cycle; responses are one-hot with the correct ids, in order.
- Locked burst:
  - Stimulus: req1 holds lock for 3 beats, then lock=0 on beat 4, while req0 is valid throughout.
  - Required: req1 gets 4 consecutive beats; req0 is granted on the next cycle.
- MAX_BURST cap:
  - Stimulus: MAX_BURST=8; req0 holds lock=1 indefinitely; req1 is valid.
  - Required: req0 gets exactly 8 beats; beat 9 goes to req1.
- Read-after-write:
  - Stimulus: req0 writes 0xAAAA.. to addr 5, then reads addr 5 on the next cycle.
  - Required: the response equals 0xAAAA.. 3 cycles after the read beat.
- Reset mid-read:
  - Stimulus: 2 reads issued; RST_i asserted for 1 cycle, 1 cycle later.
  - Required: no rsp_valid_o ever appears; all outputs 0; rr_ptr=0, so req0 wins first after reset.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared line/address types for the SRAM access path.
package sram_pkg;
  localparam int BITWIDTH = 256;
  localparam int WIDTH    = 16;

  typedef logic [BITWIDTH-1:0][WIDTH-1:0] line_t;
  typedef logic [WIDTH-1:0]               addr_t;
  typedef enum logic {ARB, LOCK}          arb_state_e;
endpackage

// File: rtl/sram_rr_arbiter.sv
// Round-robin priority scan starting at rr_ptr; pointer moves past each winner.
module sram_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      gnt_idx_o
);
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx = (int'(rr_ptr_q) + o) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IW'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found)
      rr_ptr_d = (gnt_idx_o == IW'(NUM_REQ-1)) ? '0 : gnt_idx_o + IW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one single-port line SRAM between NUM_REQ requesters with locked bursts
// and a fixed-latency tagged read return.
module sram_access_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 8
) (
  input  logic                                     CKL_i,
  input  logic                                     RST_i,
  input  logic [NUM_REQ-1:0]                       req_valid_i,
  output logic [NUM_REQ-1:0]                       req_ready_o,
  input  logic [NUM_REQ-1:0]                       req_we_i,
  input  logic [NUM_REQ-1:0]                       req_lock_i,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]            req_addr_i,
  input  logic [NUM_REQ-1:0][BITWIDTH-1:0][WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]                       rsp_valid_o,
  output logic [BITWIDTH-1:0][WIDTH-1:0]           rsp_rdata_o,
  output logic                                     SRAM_CE_o,
  output logic                                     SRAM_WE_o,
  output logic [WIDTH-1:0]                         SRAM_ADDR_o,
  output logic [BITWIDTH-1:0][WIDTH-1:0]           SRAM_WDATA_o,
  input  logic [BITWIDTH-1:0][WIDTH-1:0]           SRAM_RDATA_i
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e              state_q;
  logic [IW-1:0]           owner_q;
  logic [CW-1:0]           burst_cnt_q;
  logic [NUM_REQ-1:0]      req_mask;
  logic [NUM_REQ-1:0]      gnt;
  logic [IW-1:0]           gnt_idx;
  logic                    beat;
  logic [READ_LAT:0]       tag_vld_q;
  logic [READ_LAT:0][IW-1:0] tag_id_q;

  // While locked only the owner is visible to the scan, so it always wins.
  always_comb begin
    req_mask = req_valid_i;
    if (RST_i)                req_mask = '0;
    else if (state_q == LOCK) req_mask = req_valid_i & (NUM_REQ'(1) << owner_q);
  end

  sram_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i     (CKL_i),
    .rst_i     (RST_i),
    .req_i     (req_mask),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign beat        = |gnt;

  always_ff @(posedge CKL_i) begin
    if (RST_i) begin
      state_q     <= ARB;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (beat && req_lock_i[gnt_idx] && (MAX_BURST > 1)) begin
            state_q     <= LOCK;
            owner_q     <= gnt_idx;
            burst_cnt_q <= CW'(1);
          end
        end
        LOCK: begin
          if (!req_valid_i[owner_q]) begin
            state_q     <= ARB;
            burst_cnt_q <= '0;
          end else if (beat) begin
            if (!req_lock_i[owner_q] || (burst_cnt_q + CW'(1)) >= CW'(MAX_BURST)) begin
              state_q     <= ARB;
              burst_cnt_q <= '0;
            end else begin
              burst_cnt_q <= burst_cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  always_ff @(posedge CKL_i) begin
    if (RST_i) begin
      SRAM_CE_o    <= 1'b0;
      SRAM_WE_o    <= 1'b0;
      SRAM_ADDR_o  <= '0;
      SRAM_WDATA_o <= '0;
    end else begin
      SRAM_CE_o <= beat;
      SRAM_WE_o <= beat & req_we_i[gnt_idx];
      if (beat) begin
        SRAM_ADDR_o  <= req_addr_i[gnt_idx];
        SRAM_WDATA_o <= req_wdata_i[gnt_idx];
      end
    end
  end

  // Stage READ_LAT lines up with valid SRAM_RDATA_i for the tagged read.
  always_ff @(posedge CKL_i) begin
    if (RST_i) begin
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
    end else begin
      tag_vld_q[0] <= beat & ~req_we_i[gnt_idx];
      tag_id_q[0]  <= gnt_idx;
      for (int s = 1; s <= READ_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      rsp_valid_o <= tag_vld_q[READ_LAT] ? (NUM_REQ'(1) << tag_id_q[READ_LAT]) : '0;
      if (tag_vld_q[READ_LAT]) rsp_rdata_o <= SRAM_RDATA_i;
    end
  end
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with a READ_LAT=1 behavioural SRAM.
module tb_sram_access_arbiter;
  import sram_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      valid, ready, we, lock, rsp_valid;
  logic [1:0][WIDTH-1:0] addr;
  logic [1:0][BITWIDTH-1:0][WIDTH-1:0] wdata;
  line_t           rsp_rdata, swdata, srdata, aa, zl;
  logic            ce, swe;
  addr_t           saddr;
  int              checks = 0;
  int              errors = 0;
  line_t           mem [addr_t];
  addr_t           exp_addr [0:7];
  int              c0, c1, g;

  always #5 clk = ~clk;

  sram_access_arbiter #(.NUM_REQ(2), .READ_LAT(1), .MAX_BURST(8)) dut (
    .CKL_i(clk), .RST_i(rst),
    .req_valid_i(valid), .req_ready_o(ready), .req_we_i(we), .req_lock_i(lock),
    .req_addr_i(addr), .req_wdata_i(wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .SRAM_CE_o(ce), .SRAM_WE_o(swe), .SRAM_ADDR_o(saddr),
    .SRAM_WDATA_o(swdata), .SRAM_RDATA_i(srdata)
  );

  // Unwritten lines: element j = j for address 0x0010, distinct elsewhere.
  function automatic line_t pat(addr_t a);
    line_t l;
    for (int j = 0; j < BITWIDTH; j++) l[j] = 16'(j) ^ {a[7:0] ^ 8'h10, 8'h00};
    return l;
  endfunction

  always @(posedge clk) begin
    if (ce) begin
      if (swe) mem[saddr] = swdata;
      else     srdata <= mem.exists(saddr) ? mem[saddr] : pat(saddr);
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(string tag, line_t obs, line_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed[1:0]=%0h expected[1:0]=%0h", tag, {obs[1], obs[0]}, {exp[1], exp[0]});
    end
  endtask

  task automatic idle();
    valid = '0; we = '0; lock = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < BITWIDTH; j++) begin aa[j] = 16'hAAAA; zl[j] = '0; end
    rst = 1'b1; valid = 2'b11; we = '0; lock = '0; addr = '0; wdata = '0;

    // reset state
    @(negedge clk); #1;
    chk("rst_ready", 32'(ready), 32'h0);
    @(negedge clk);
    chk("rst_ce", 32'(ce), 0); chk("rst_we", 32'(swe), 0); chk("rst_addr", 32'(saddr), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk_line("rst_wdata", swdata, zl); chk_line("rst_rdata", rsp_rdata, zl);
    rst = 1'b0; idle();

    // single read
    @(negedge clk); valid = 2'b01; addr[0] = 16'h0010; #1;
    chk("sr_ready", 32'(ready), 32'h1);
    @(negedge clk); idle();
    chk("sr_ce", 32'(ce), 1); chk("sr_we", 32'(swe), 0); chk("sr_addr", 32'(saddr), 32'h10);
    chk("sr_rsp_early1", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("sr_ce_off", 32'(ce), 0); chk("sr_rsp_early2", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("sr_rsp", 32'(rsp_valid), 32'h1); chk_line("sr_data", rsp_rdata, pat(16'h0010));
    @(negedge clk);
    chk("sr_rsp_off", 32'(rsp_valid), 0); chk_line("sr_hold", rsp_rdata, pat(16'h0010));

    // round-robin contention, 4 unlocked reads each
    do_reset();
    c0 = 0; c1 = 0;
    for (int n = 0; n < 11; n++) begin
      @(negedge clk);
      valid = {c1 < 4, c0 < 4}; we = '0; lock = '0;
      addr[0] = 16'h0020 + 16'(c0); addr[1] = 16'h0030 + 16'(c1);
      #1;
      if (n < 8) begin
        g = n % 2;
        chk("rr_grant", 32'(ready), 32'(1 << g));
        exp_addr[n] = g ? 16'h0030 + 16'(c1) : 16'h0020 + 16'(c0);
        if (g == 0) c0++; else c1++;
      end else begin
        chk("rr_grant_idle", 32'(ready), 0);
      end
      if (n >= 1 && n <= 8) begin
        chk("rr_ce", 32'(ce), 1); chk("rr_addr", 32'(saddr), 32'(exp_addr[n-1]));
      end
      if (n >= 3) begin
        chk("rr_rsp", 32'(rsp_valid), 32'(1 << ((n - 3) % 2)));
        chk_line("rr_data", rsp_rdata, pat(exp_addr[n-3]));
      end else begin
        chk("rr_rsp_none", 32'(rsp_valid), 0);
      end
    end
    idle();

    // locked burst: req1 locks 3 beats, releases on beat 4
    do_reset();
    @(negedge clk); valid = 2'b01; we = 2'b01; addr[0] = 16'h0050; #1;
    chk("lk_prime", 32'(ready), 32'h1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      valid = 2'b11; we = 2'b11; lock = {n < 3, 1'b0}; #1;
      chk("lk_grant", 32'(ready), (n < 4) ? 32'h2 : 32'h1);
    end
    idle();

    // MAX_BURST cap: req0 locked forever
    do_reset();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      valid = 2'b11; we = 2'b11; lock = 2'b01; #1;
      chk("cap_grant", 32'(ready), (n == 8) ? 32'h2 : 32'h1);
    end
    idle();

    // read-after-write
    do_reset();
    @(negedge clk); valid = 2'b01; we = 2'b01; addr[0] = 16'h0005; wdata[0] = aa; #1;
    chk("raw_wr_ready", 32'(ready), 32'h1);
    @(negedge clk); we = 2'b00; #1;
    chk("raw_rd_ready", 32'(ready), 32'h1);
    @(negedge clk); idle();
    @(negedge clk);
    chk("raw_no_wr_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("raw_rsp", 32'(rsp_valid), 32'h1); chk_line("raw_data", rsp_rdata, aa);

    // reset mid-read
    @(negedge clk); valid = 2'b10; we = 2'b00; addr[1] = 16'h0041; #1;
    chk("mr_rd1", 32'(ready), 32'h2);
    @(negedge clk); valid = 2'b01; addr[0] = 16'h0040; #1;
    chk("mr_rd2", 32'(ready), 32'h1);
    @(negedge clk); rst = 1'b1; valid = 2'b11; #1;
    chk("mr_rst_ready", 32'(ready), 0);
    @(negedge clk); rst = 1'b0; valid = 2'b11; we = 2'b11; #1;
    chk("mr_post_grant", 32'(ready), 32'h1);
    chk("mr_ce", 32'(ce), 0); chk("mr_we", 32'(swe), 0); chk("mr_addr", 32'(saddr), 0);
    chk("mr_rsp0", 32'(rsp_valid), 0);
    chk_line("mr_wdata", swdata, zl); chk_line("mr_rdata", rsp_rdata, zl);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); idle();
      chk("mr_rsp_none", 32'(rsp_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
